pc_fetch_redirect: RTL and testbench

//  Fetch-side consumer of the branch unit's redirect (pc_sel_i / br_pc_i). It owns the PC register
//  and issues requests to instruction memory over a req/ready handshake. It fills the IF/ID register,

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_skid_buf.sv | 46 ++++
 rtl/pc_fetch_redirect.sv | 177 +++++++++++++++++
 tb/tb_pc_fetch_redirect.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch/redirect slice.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    PEND  = 2'd1,
    TRAP  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] PC_INC     = 32'd4;
  localparam logic [1:0]  ALIGN_MASK = 2'b11;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return |(addr[1:0] & ALIGN_MASK);
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, instr} holding buffer used while the IF/ID register is stalled.
module fetch_skid_buf
  import fetch_pkg::*;
#(
  parameter int PC_W = 9
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            unload,
  input  logic            clear,
  input  logic [PC_W-1:0] in_pc,
  input  logic [31:0]     in_instr,
  output logic            full,
  output logic [PC_W-1:0] out_pc,
  output logic [31:0]     out_instr
);

  logic            full_r;
  logic [PC_W-1:0] pc_r;
  logic [31:0]     instr_r;

  // clear beats load so a redirect always discards a wrong-path entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_r  <= 1'b0;
      pc_r    <= '0;
      instr_r <= 32'd0;
    end else if (clear) begin
      full_r  <= 1'b0;
    end else if (load) begin
      full_r  <= 1'b1;
      pc_r    <= in_pc;
      instr_r <= in_instr;
    end else if (unload) begin
      full_r  <= 1'b0;
    end else begin
      full_r  <= full_r;
    end
  end

  assign full      = full_r;
  assign out_pc    = pc_r;
  assign out_instr = instr_r;

endmodule

// File: rtl/pc_fetch_redirect.sv
// PC register, imem request handshake, IF/ID register and branch-redirect handling.
module pc_fetch_redirect
  import fetch_pkg::*;
#(
  parameter int              PC_W     = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pc_sel_i,
  input  logic [31:0]      br_pc_i,
  input  logic             stall_i,
  input  logic             imem_ready_i,
  input  logic [31:0]      instr_i,
  output logic             imem_req_o,
  output logic [PC_W-1:0]  imem_addr_o,
  output logic [PC_W-1:0]  if_pc_o,
  output logic [31:0]      if_instr_o,
  output logic             if_valid_o,
  output logic             flush_o,
  output logic             misalign_o,
  output logic [CNT_W-1:0] redirect_cnt_o
);

  localparam logic [PC_W-1:0]  PC_STEP = PC_INC[PC_W-1:0];
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  fetch_state_t     state_r, state_n;
  logic [PC_W-1:0]  pc_r, pc_n;
  logic [PC_W-1:0]  pend_pc_r, pend_pc_n;
  logic [PC_W-1:0]  if_pc_r, if_pc_n;
  logic [31:0]      if_instr_r, if_instr_n;
  logic             if_valid_r, if_valid_n;
  logic             misalign_r, misalign_n;
  logic [CNT_W-1:0] cnt_r, cnt_n;

  logic             skid_load_s, skid_unload_s, skid_clear_s, skid_full_s;
  logic [PC_W-1:0]  skid_pc_s;
  logic [31:0]      skid_instr_s;

  logic             req_s, acc_s, redirect_s;
  logic [PC_W-1:0]  target_s;
  logic             unused_br_hi_s;

  fetch_skid_buf #(.PC_W(PC_W)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .load      (skid_load_s),
    .unload    (skid_unload_s),
    .clear     (skid_clear_s),
    .in_pc     (pc_r),
    .in_instr  (instr_i),
    .full      (skid_full_s),
    .out_pc    (skid_pc_s),
    .out_instr (skid_instr_s)
  );

  assign req_s          = ~reset & (state_r != TRAP) & ~skid_full_s;
  assign acc_s          = req_s & imem_ready_i;
  assign redirect_s     = pc_sel_i & (state_r != TRAP);
  assign target_s       = br_pc_i[PC_W-1:0];
  assign unused_br_hi_s = ^br_pc_i;

  // Next-state: a redirect overrides stall and sequential advance
  always_comb begin
    state_n       = state_r;
    pc_n          = pc_r;
    pend_pc_n     = pend_pc_r;
    if_pc_n       = if_pc_r;
    if_instr_n    = if_instr_r;
    if_valid_n    = if_valid_r;
    misalign_n    = misalign_r;
    cnt_n         = cnt_r;
    skid_load_s   = 1'b0;
    skid_unload_s = 1'b0;
    skid_clear_s  = 1'b0;

    if (redirect_s) begin
      cnt_n        = (&cnt_r) ? cnt_r : cnt_r + CNT_ONE;
      if_valid_n   = 1'b0;
      skid_clear_s = 1'b1;
      if (is_misaligned(br_pc_i)) begin
        misalign_n = 1'b1;
        state_n    = TRAP;
      end else if (state_r == FETCH) begin
        if (acc_s) begin
          pc_n = target_s;
        end else begin
          pend_pc_n = target_s;
          state_n   = PEND;
        end
      end else begin
        // newest redirect wins; the in-flight response is discarded
        pend_pc_n = target_s;
        if (acc_s) begin
          pc_n    = target_s;
          state_n = FETCH;
        end else begin
          state_n = PEND;
        end
      end
    end else begin
      case (state_r)
        FETCH: begin
          if (acc_s) begin
            pc_n = pc_r + PC_STEP;
          end else begin
            pc_n = pc_r;
          end
          if (stall_i) begin
            skid_load_s = acc_s;
          end else if (skid_full_s) begin
            if_pc_n       = skid_pc_s;
            if_instr_n    = skid_instr_s;
            if_valid_n    = 1'b1;
            skid_unload_s = 1'b1;
          end else begin
            if_pc_n    = pc_r;
            if_instr_n = instr_i;
            if_valid_n = acc_s;
          end
        end
        PEND: begin
          if_valid_n = 1'b0;
          if (acc_s) begin
            pc_n    = pend_pc_r;
            state_n = FETCH;
          end else begin
            state_n = PEND;
          end
        end
        TRAP: begin
          if_valid_n = 1'b0;
          state_n    = TRAP;
        end
        default: begin
          if_valid_n = 1'b0;
          state_n    = TRAP;
        end
      endcase
    end
  end

  // State, PC and IF/ID registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= FETCH;
      pc_r       <= RESET_PC;
      pend_pc_r  <= '0;
      if_pc_r    <= '0;
      if_instr_r <= 32'd0;
      if_valid_r <= 1'b0;
      misalign_r <= 1'b0;
      cnt_r      <= '0;
    end else begin
      state_r    <= state_n;
      pc_r       <= pc_n;
      pend_pc_r  <= pend_pc_n;
      if_pc_r    <= if_pc_n;
      if_instr_r <= if_instr_n;
      if_valid_r <= if_valid_n;
      misalign_r <= misalign_n;
      cnt_r      <= cnt_n;
    end
  end

  assign imem_req_o     = req_s;
  assign imem_addr_o    = pc_r;
  assign flush_o        = redirect_s;
  assign if_pc_o        = if_pc_r;
  assign if_instr_o     = if_instr_r;
  assign if_valid_o     = if_valid_r;
  assign misalign_o     = misalign_r;
  assign redirect_cnt_o = cnt_r;

endmodule

// File: tb/tb_pc_fetch_redirect.sv
// Directed bench for pc_fetch_redirect; a second instance with a 2-bit counter checks saturation.
module tb_pc_fetch_redirect;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, pc_sel, stall, ready;
  logic [31:0] br_pc;
  logic [31:0] instr, instr2;

  logic        req, valid, flush, mis;
  logic [8:0]  addr, if_pc;
  logic [31:0] if_instr;
  logic [15:0] cnt;

  logic        req2, valid2, flush2, mis2;
  logic [8:0]  addr2, if_pc2;
  logic [31:0] if_instr2;
  logic [1:0]  cnt2;

  int errors = 0;
  int checks = 0;

  // imem model: instruction word encodes its own address
  assign instr  = {16'hC0DE, 7'd0, addr};
  assign instr2 = {16'hC0DE, 7'd0, addr2};

  pc_fetch_redirect dut (
    .clk(clk), .reset(reset), .pc_sel_i(pc_sel), .br_pc_i(br_pc), .stall_i(stall),
    .imem_ready_i(ready), .instr_i(instr), .imem_req_o(req), .imem_addr_o(addr),
    .if_pc_o(if_pc), .if_instr_o(if_instr), .if_valid_o(valid), .flush_o(flush),
    .misalign_o(mis), .redirect_cnt_o(cnt)
  );

  pc_fetch_redirect #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .pc_sel_i(pc_sel), .br_pc_i(br_pc), .stall_i(stall),
    .imem_ready_i(ready), .instr_i(instr2), .imem_req_o(req2), .imem_addr_o(addr2),
    .if_pc_o(if_pc2), .if_instr_o(if_instr2), .if_valid_o(valid2), .flush_o(flush2),
    .misalign_o(mis2), .redirect_cnt_o(cnt2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; pc_sel = 1'b0; br_pc = 32'd0; stall = 1'b0; ready = 1'b0;
    tick; tick;
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL rst_req got=%b exp=0", req); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", valid); end
    checks++; if (if_pc !== 9'h0) begin errors++; $display("FAIL rst_if_pc got=%h exp=0", if_pc); end
    checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL rst_if_instr got=%h exp=0", if_instr); end
    checks++; if (mis !== 1'b0) begin errors++; $display("FAIL rst_mis got=%b exp=0", mis); end
    checks++; if (cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt got=%0d exp=0", cnt); end
    checks++; if (addr !== 9'h0) begin errors++; $display("FAIL rst_addr got=%h exp=0", addr); end
    reset = 1'b0;
  endtask

  task automatic test_sequential;
    ready = 1'b1;
    #1;
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL seq_req got=%b exp=1", req); end
    checks++; if (addr !== 9'h000) begin errors++; $display("FAIL seq_addr0 got=%h exp=000", addr); end
    tick;
    checks++; if (addr !== 9'h004) begin errors++; $display("FAIL seq_addr1 got=%h exp=004", addr); end
    checks++; if (if_pc !== 9'h000 || valid !== 1'b1) begin errors++; $display("FAIL seq_if0 got=%h/%b exp=000/1", if_pc, valid); end
    checks++; if (if_instr !== 32'hC0DE0000) begin errors++; $display("FAIL seq_instr0 got=%h exp=C0DE0000", if_instr); end
    tick;
    checks++; if (addr !== 9'h008) begin errors++; $display("FAIL seq_addr2 got=%h exp=008", addr); end
    checks++; if (if_pc !== 9'h004 || if_instr !== 32'hC0DE0004) begin errors++; $display("FAIL seq_if1 got=%h/%h exp=004/C0DE0004", if_pc, if_instr); end
  endtask

  task automatic test_redirect;
    pc_sel = 1'b1; br_pc = 32'h40;
    #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL redir_flush got=%b exp=1", flush); end
    tick;
    pc_sel = 1'b0;
    #1;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL redir_flush_off got=%b exp=0", flush); end
    checks++; if (addr !== 9'h040) begin errors++; $display("FAIL redir_addr got=%h exp=040", addr); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL redir_squash got=%b exp=0", valid); end
    checks++; if (cnt !== 16'd1) begin errors++; $display("FAIL redir_cnt got=%0d exp=1", cnt); end
    tick;
    checks++; if (if_pc !== 9'h040 || valid !== 1'b1 || if_instr !== 32'hC0DE0040) begin
      errors++; $display("FAIL redir_first got=%h/%b/%h exp=040/1/C0DE0040", if_pc, valid, if_instr); end
    checks++; if (addr !== 9'h044) begin errors++; $display("FAIL redir_next got=%h exp=044", addr); end
  endtask

  task automatic test_pend_redirect;
    ready = 1'b0;
    tick;
    checks++; if (addr !== 9'h044 || req !== 1'b1) begin errors++; $display("FAIL pend_wait got=%h/%b exp=044/1", addr, req); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL pend_bubble got=%b exp=0", valid); end
    pc_sel = 1'b1; br_pc = 32'h80;
    #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL pend_flush got=%b exp=1", flush); end
    tick;
    br_pc = 32'h90;
    #1;
    checks++; if (addr !== 9'h044 || cnt !== 16'd2) begin errors++; $display("FAIL pend_hold1 got=%h/%0d exp=044/2", addr, cnt); end
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL pend_flush2 got=%b exp=1", flush); end
    tick;
    pc_sel = 1'b0;
    tick;
    checks++; if (addr !== 9'h044 || cnt !== 16'd3) begin errors++; $display("FAIL pend_hold2 got=%h/%0d exp=044/3", addr, cnt); end
    checks++; if (cnt2 !== 2'd3) begin errors++; $display("FAIL pend_cnt2 got=%0d exp=3", cnt2); end
    ready = 1'b1;
    tick;
    checks++; if (addr !== 9'h090) begin errors++; $display("FAIL pend_target got=%h exp=090", addr); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL pend_drop got=%b exp=0", valid); end
    tick;
    checks++; if (if_pc !== 9'h090 || valid !== 1'b1 || addr !== 9'h094) begin
      errors++; $display("FAIL pend_first got=%h/%b/%h exp=090/1/094", if_pc, valid, addr); end
  endtask

  task automatic test_stall_skid;
    stall = 1'b1;
    #1;
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL stall_req0 got=%b exp=1", req); end
    tick;
    checks++; if (req !== 1'b0 || addr !== 9'h098) begin errors++; $display("FAIL stall_skid got=%b/%h exp=0/098", req, addr); end
    checks++; if (if_pc !== 9'h090 || valid !== 1'b1) begin errors++; $display("FAIL stall_hold got=%h/%b exp=090/1", if_pc, valid); end
    tick; tick;
    checks++; if (req !== 1'b0 || if_pc !== 9'h090 || addr !== 9'h098) begin
      errors++; $display("FAIL stall_hold3 got=%b/%h/%h exp=0/090/098", req, if_pc, addr); end
    stall = 1'b0;
    tick;
    checks++; if (if_pc !== 9'h094 || if_instr !== 32'hC0DE0094 || valid !== 1'b1) begin
      errors++; $display("FAIL stall_unload got=%h/%h/%b exp=094/C0DE0094/1", if_pc, if_instr, valid); end
    checks++; if (req !== 1'b1 || addr !== 9'h098) begin errors++; $display("FAIL stall_resume got=%b/%h exp=1/098", req, addr); end
    tick;
    checks++; if (if_pc !== 9'h098 || valid !== 1'b1 || addr !== 9'h09C) begin
      errors++; $display("FAIL stall_next got=%h/%b/%h exp=098/1/09C", if_pc, valid, addr); end
  endtask

  task automatic test_wrap_saturate;
    pc_sel = 1'b1; br_pc = 32'hFFFF_F1FC;
    tick;
    pc_sel = 1'b0;
    #1;
    checks++; if (addr !== 9'h1FC) begin errors++; $display("FAIL wrap_trunc got=%h exp=1FC", addr); end
    checks++; if (cnt !== 16'd4) begin errors++; $display("FAIL wrap_cnt got=%0d exp=4", cnt); end
    checks++; if (cnt2 !== 2'd3) begin errors++; $display("FAIL sat_cnt2 got=%0d exp=3", cnt2); end
    tick;
    checks++; if (addr !== 9'h000) begin errors++; $display("FAIL wrap_addr got=%h exp=000", addr); end
    checks++; if (if_pc !== 9'h1FC || valid !== 1'b1) begin errors++; $display("FAIL wrap_if got=%h/%b exp=1FC/1", if_pc, valid); end
  endtask

  task automatic test_misalign_trap;
    pc_sel = 1'b1; br_pc = 32'h42;
    #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL mis_flush got=%b exp=1", flush); end
    tick;
    pc_sel = 1'b0;
    #1;
    checks++; if (mis !== 1'b1 || req !== 1'b0 || valid !== 1'b0) begin
      errors++; $display("FAIL mis_trap got=%b/%b/%b exp=1/0/0", mis, req, valid); end
    checks++; if (cnt !== 16'd5) begin errors++; $display("FAIL mis_cnt got=%0d exp=5", cnt); end
    tick;
    checks++; if (req !== 1'b0 || valid !== 1'b0 || mis !== 1'b1) begin
      errors++; $display("FAIL mis_stay got=%b/%b/%b exp=0/0/1", req, valid, mis); end
    pc_sel = 1'b1; br_pc = 32'h100;
    #1;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL trap_flush got=%b exp=0", flush); end
    tick;
    pc_sel = 1'b0;
    #1;
    checks++; if (req !== 1'b0 || cnt !== 16'd5) begin errors++; $display("FAIL trap_ignore got=%b/%0d exp=0/5", req, cnt); end
  endtask

  task automatic test_async_reset;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    #1;
    checks++; if (mis !== 1'b0 || req !== 1'b1) begin errors++; $display("FAIL rst_leave_trap got=%b/%b exp=0/1", mis, req); end
    tick; tick;
    checks++; if (if_pc !== 9'h004 || valid !== 1'b1 || addr !== 9'h008) begin
      errors++; $display("FAIL rst_refetch got=%h/%b/%h exp=004/1/008", if_pc, valid, addr); end
    ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checks++; if (req !== 1'b0 || valid !== 1'b0 || addr !== 9'h000) begin
      errors++; $display("FAIL arst_a got=%b/%b/%h exp=0/0/000", req, valid, addr); end
    checks++; if (if_pc !== 9'h000 || if_instr !== 32'h0 || cnt !== 16'd0 || mis !== 1'b0) begin
      errors++; $display("FAIL arst_b got=%h/%h/%0d/%b exp=000/0/0/0", if_pc, if_instr, cnt, mis); end
    tick;
    reset = 1'b0;
  endtask

  initial begin
    test_reset;
    test_sequential;
    test_redirect;
    test_pend_redirect;
    test_stall_skid;
    test_wrap_saturate;
    test_misalign_trap;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
